adc78h90_poller: RTL
====================

// Module: adc78h90_poller
// PURPOSE
//  Free-running SPI master for the ADC78H90CIMT 8-ch 12-bit housekeeping ADC on ADCMOSI/ADCCLK/ADCMISO/nADCCS.
//  Polls channels 0..NCH-1 round-robin and emits one {channel, 12-bit result} strobe per frame.
//  Sits between the ADC pins and the core's telemetry/status registers (forward/reverse power, supply, temperature).
// PARAMETERS
//  CLK_DIV     4   ADCCLK half-period in clk cycles (>=2); ADCCLK = clk/(2*CLK_DIV).
//  NCH         4   channels polled, 1..8; address wraps NCH-1 -> 0.
//  GAP_CYCLES  16  clk cycles nADCCS held high between frames (>=1).
// PORTS
//  clk          in   1   single clock; all logic on rising edge.
//  rst          in   1   synchronous, active-high reset.
//  enable       in   1   1 = keep polling; sampled only in IDLE and at end of GAP.
//  busy         out  1   1 whenever state != IDLE.
//  result_valid out  1   one-cycle strobe; result_ch/result_data valid this cycle.
//  result_ch    out  3   channel the result belongs to.
//  result_data  out  12  conversion result, straight binary.
//  nADCCS       out  1   ADC chip select, active low.
//  ADCCLK       out  1   SPI clock, idles high.
//  ADCMOSI      out  1   control word to ADC DIN.
//  ADCMISO      in   1   ADC DOUT.
// BEHAVIOUR
//  Reset: nADCCS=1, ADCCLK=1, ADCMOSI=0, busy=0, result_valid=0, result_ch=0, result_data=0,
//   next address=0, primed=0, state=IDLE. Reset mid-frame aborts on the next edge; no partial result is emitted.
//  Frame word (MSB first): {2'b00, addr[2:0], 11'b0}. DOUT frame: 4 leading zeros + 12 data bits;
//   keep captured[11:0], ignore captured[15:12] regardless of value.
//  States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> (SETUP if enable else IDLE).
//   IDLE : outputs at reset values; enable=1 -> SETUP next cycle.
//   SETUP: nADCCS=0, ADCCLK=1, ADCMOSI=frame[15]; lasts CLK_DIV cycles.
//   SHIFT: 16 bit periods. Each period = CLK_DIV cycles ADCCLK=0, then CLK_DIV cycles ADCCLK=1.
//          ADCMOSI updates to the next frame bit when ADCCLK falls (bit k in period 15-k).
//          ADCMISO is shifted into captured[0] on the clk edge that drives ADCCLK 0->1.
//   HOLD : ADCCLK=1, nADCCS=0 for CLK_DIV cycles; then nADCCS=1, ADCMOSI=0.
//   GAP  : nADCCS=1 for GAP_CYCLES cycles. enable is sampled on the last GAP cycle.
//  nADCCS low time per frame: exactly CLK_DIV*34 cycles. Frame period: CLK_DIV*34 + GAP_CYCLES.
//  Pipeline: the ADC returns the channel addressed in the previous frame.
//   On HOLD exit: if primed=1, result_valid=1 for one cycle, result_ch = previous address,
//   result_data = captured[11:0]. primed is then set to 1 and the address advances
//   (addr == NCH-1 ? 0 : addr+1).
//  Entry to SETUP from IDLE clears primed, so the first frame after reset or re-enable emits no strobe.
//   Address continues from where it stopped; it is not reset to 0.
//  enable dropped mid-frame: the frame completes, including its strobe if primed; returns to IDLE after GAP.
//  result_ch/result_data hold their last value between strobes.
//  NCH=1: every frame addresses ch0; every strobe reports ch0.
// TESTING
//  1 Reset: hold rst 3 cycles with enable=1 -> nADCCS=1, ADCCLK=1, busy=0, result_valid=0 throughout.
//  2 CLK_DIV=2, NCH=3, GAP=16; ADC model returns 0x0100*ch+0x0AB
//    -> no strobe in frame 1; strobes ch0=0x0AB, ch1=0x1AB, ch2=0x2AB, ch0=0x0AB in order;
//       nADCCS low exactly 68 cycles per frame; strobe spacing 84 cycles.
//  3 Decode ADCMOSI at ADCCLK rising edges -> ADD2..0 sequence 0,1,2,0,1; other 13 bits 0;
//    exactly 16 rising ADCCLK edges per CS-low window.
//  4 Model drives DOUT word 0xF123 -> result_data=0x123 (leading bits ignored).
//  5 Drop enable during SHIFT of frame 3 -> frame 3 completes, its strobe appears, then busy=0 and nADCCS stays 1;
//    re-enable -> first new frame emits no strobe.
//  6 Assert rst in mid-SHIFT -> next cycle nADCCS=1, ADCCLK=1, no strobe; after release with enable=1,
//    polling restarts at ch0.

Source files
------------

// File: rtl/adc78h90_poller.sv
// ----------------------------------------------------------------------------
// adc78h90_poller
//
// Free-running SPI master for the ADC78H90 8-channel 12-bit housekeeping ADC.
// Polls channels 0..NCH-1 round-robin. Each frame emits one result strobe
// carrying the channel and the 12-bit conversion. The ADC is pipelined by one
// frame: the data clocked out during a frame belongs to the channel addressed
// in the previous frame. So the first frame after reset or re-enable only
// primes the pipeline and does not strobe.
//
// Frame timing (clk cycles, nADCCS low = 34*CLK_DIV):
//   SETUP CLK_DIV | SHIFT 16 x (CLK_DIV low + CLK_DIV high) | HOLD CLK_DIV
//   followed by GAP_CYCLES with nADCCS high.
//
// Parameters
//   CLK_DIV     ADCCLK half-period in clk cycles (>= 2)
//   NCH         channels polled, 1..8
//   GAP_CYCLES  clk cycles nADCCS stays high between frames (>= 1)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   enable        keep polling; sampled in IDLE and on the last GAP cycle
//   busy          high whenever the sequencer is not IDLE
//   result_valid  one-cycle strobe; result_ch/result_data valid this cycle
//   result_ch     channel the result belongs to (held between strobes)
//   result_data   12-bit straight-binary result (held between strobes)
//   nADCCS        ADC chip select, active low
//   ADCCLK        SPI clock, idles high
//   ADCMOSI       control word to ADC DIN
//   ADCMISO       ADC DOUT
// ----------------------------------------------------------------------------
module adc78h90_poller #(
    parameter int CLK_DIV    = 4,
    parameter int NCH        = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        busy,
    output logic        result_valid,
    output logic [2:0]  result_ch,
    output logic [11:0] result_data,
    output logic        nADCCS,
    output logic        ADCCLK,
    output logic        ADCMOSI,
    input  logic        ADCMISO
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [2:0]    LAST_CH  = 3'(NCH - 1);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;          // cycle counter within the current phase
    logic [3:0]    bit_idx, bit_d;      // frame bit currently on ADCMOSI
    logic          sck_low, sck_low_d;  // SHIFT: 1 = low half of the bit period
    logic [2:0]    addr, addr_d;        // channel addressed by the current frame
    logic [2:0]    prev_addr, prev_addr_d;
    logic          primed, primed_d;
    // Only the last 12 DOUT bits are kept; the 4 leading bits shift out the top.
    logic [11:0]   cap, cap_d;
    logic          rv_d;
    logic [2:0]    rch_d;
    logic [11:0]   rdata_d;
    logic          ncs_d, sclk_d, mosi_d;
    logic [15:0]   frame;

    assign frame = {2'b00, addr, 11'b0};
    assign busy  = (state != IDLE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; that is what keeps this block free of latches.
        state_d     = state;
        cnt_d       = cnt;
        bit_d       = bit_idx;
        sck_low_d   = sck_low;
        addr_d      = addr;
        prev_addr_d = prev_addr;
        primed_d    = primed;
        cap_d       = cap;
        rv_d        = 1'b0;
        rch_d       = result_ch;
        rdata_d     = result_data;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_d  = SETUP;
                    cnt_d    = '0;
                    primed_d = 1'b0;  // data of the first frame belongs to a stale address
                end
            end
            SETUP: begin
                if (cnt == DIV_LAST) begin
                    state_d   = SHIFT;
                    cnt_d     = '0;
                    sck_low_d = 1'b1;
                    bit_d     = 4'd15;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_d = '0;
                    if (sck_low) begin
                        // This edge raises ADCCLK: sample DOUT here.
                        sck_low_d = 1'b0;
                        cap_d     = {cap[10:0], ADCMISO};
                    end else if (bit_idx == 4'd0) begin
                        state_d = HOLD;
                    end else begin
                        // ADCCLK falls: present the next control bit.
                        sck_low_d = 1'b1;
                        bit_d     = bit_idx - 4'd1;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            HOLD: begin
                if (cnt == DIV_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    if (primed) begin
                        rv_d    = 1'b1;
                        rch_d   = prev_addr;
                        rdata_d = cap;
                    end
                    primed_d    = 1'b1;
                    prev_addr_d = addr;
                    addr_d      = (addr == LAST_CH) ? 3'd0 : addr + 3'd1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = enable ? SETUP : IDLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin values are decoded from the next state and registered, so the
        // SPI pins come straight from flops and cannot glitch.
        ncs_d  = !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
        sclk_d = !(state_d == SHIFT && sck_low_d);
        case (state_d)
            SETUP:   mosi_d = frame[15];
            SHIFT:   mosi_d = frame[bit_d];
            default: mosi_d = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            sck_low      <= 1'b0;
            addr         <= 3'd0;
            prev_addr    <= 3'd0;
            primed       <= 1'b0;
            result_valid <= 1'b0;
            result_ch    <= 3'd0;
            result_data  <= 12'd0;
            nADCCS       <= 1'b1;
            ADCCLK       <= 1'b1;
            ADCMOSI      <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            bit_idx      <= bit_d;
            sck_low      <= sck_low_d;
            addr         <= addr_d;
            prev_addr    <= prev_addr_d;
            primed       <= primed_d;
            result_valid <= rv_d;
            result_ch    <= rch_d;
            result_data  <= rdata_d;
            nADCCS       <= ncs_d;
            ADCCLK       <= sclk_d;
            ADCMOSI      <= mosi_d;
        end
    end

    // NOTE: the capture register is deliberately left out of reset: all 12
    // bits are overwritten by every frame before a strobe can read them.
    always_ff @(posedge clk) begin
        cap <= cap_d;
    end

endmodule
